ncpu32k_rob: RTL and testbench
==============================

Name: ncpu32k_rob

Overview:
- Reorder buffer at the receiving end of the CDB commit channel; the CDB arbiter drives its `rob_commit_*` B-channel.
- Dispatch allocates entries in program order and returns a tag. FUs complete out of order via CDB B-packets carrying that tag.
- Entries retire in order to the register file.
- Circular buffer of 2^TAG_WIDTH entries with head/tail pointers and per-entry valid/ready bits.

Parameters:
- TAG_WIDTH, 2, log2 of entry count (DEPTH = 4).
- ID_WIDTH, 2, FU id width carried on the CDB.
- DW, 32, data width (`NCPU_DW`).
- REG_AW, 5, architectural destination register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- flush  in  1  synchronous flush of all entries.
- disp_AVALID  in  1  dispatch requests an entry.
- disp_AREADY  out  1  entry available (not full, not flush).
- disp_rd_addr  in  REG_AW  destination register of the dispatched op.
- disp_rd_we  in  1  op writes a register.
- disp_tag  out  TAG_WIDTH  tag allocated on this handshake (equals tail index).
- rob_commit_BVALID  in  1  CDB packet valid.
- rob_commit_BREADY  out  1  ROB accepts packet.
- rob_commit_BDATA  in  DW  result data.
- rob_commit_BTAG  in  TAG_WIDTH  target entry.
- rob_commit_id  in  ID_WIDTH  originating FU id.
- retire_valid  out  1  head entry complete.
- retire_ready  in  1  register file accepts retire.
- retire_data  out  DW  head result.
- retire_rd_addr  out  REG_AW  head destination.
- retire_rd_we  out  1  head write enable.
- retire_id  out  ID_WIDTH  FU id stored at commit.
- commit_err  out  1  sticky: a commit targeted a free or already-ready entry.

Behaviour:
- **Pointers:** `head` and `tail` are TAG_WIDTH+1 bits; the MSB is the wrap bit.
  - empty = (head == tail).
  - full = (low bits equal) and (MSB differs).
  - Count range 0..DEPTH.
- **Per entry:** `vld`, `rdy`, `data`, `rd_addr`, `rd_we`, `id`.
- **Reset (rst = 1, asynchronous):**
  - head = tail = 0; all `vld`/`rdy` = 0; commit_err = 0.
  - Outputs: disp_AREADY = 0, rob_commit_BREADY = 0, retire_valid = 0, disp_tag = 0.
  - The data payload is not reset.
- **Combinational outputs:**
  - disp_AREADY = ~rst & ~full & ~flush.
  - disp_tag = tail[TAG_WIDTH-1:0].
- **Dispatch handshake (disp_AVALID & disp_AREADY):**
  - Write entry[tail]: vld = 1, rdy = 0, rd_addr, rd_we.
  - tail increments with wrap.
- **Full boundary:** disp_AREADY does not consider a same-cycle retire. When full, dispatch stalls even if the head retires that cycle; it is accepted on the next cycle.
- **CDB commit:**
  - rob_commit_BREADY = ~rst & ~flush. The ROB never back-pressures the CDB otherwise.
  - On BVALID & BREADY with entry[BTAG].vld = 1 and rdy = 0: write data and id, set rdy = 1.
  - If the entry is not vld, or is already rdy: the packet is dropped, entry state is unchanged, and commit_err is set (cleared only by rst).
- **Retire:**
  - retire_valid = ~empty & entry[head].vld & entry[head].rdy.
  - Payload fields are driven combinationally from entry[head].
  - On retire_valid & retire_ready: clear entry[head].vld/rdy; head increments with wrap.
- **Latency:** a commit to the head entry in cycle N gives retire_valid = 1 in cycle N+1 (registered `rdy`). There is no commit-to-retire bypass.
- **Simultaneous events:**
  - Dispatch, commit and retire may all occur in one cycle at distinct entries.
  - Dispatch into an entry being freed the same cycle is impossible: a free slot implies not full.
  - Commit and retire on the same entry cannot coincide, because retire requires rdy already set.
- **Wrap-around:** indices wrap modulo DEPTH. The wrap bit toggles on every pass, so a full buffer and an empty buffer are distinct.
- **Flush:** priority over dispatch, commit and retire in that cycle. Next cycle: head = tail = 0, all `vld`/`rdy` = 0. commit_err is retained.
- **Mid-operation reset:** rst asserted in any state immediately forces the reset values above. Packets in flight are lost.

Test Plan:
1. **Dispatch to full:** after reset, dispatch 4 ops (rd 1,2,3,4) -> disp_tag 0,1,2,3; disp_AREADY = 0 after the 4th; a 5th AVALID is held off.
2. **Out-of-order commit:** commits tag 2 (data 32'h741235, id 2), tag 0 (32'hbadbeef, id 0), tag 1, tag 3 ->
   - retire_valid rises the cycle after tag 0's commit, with data 32'hbadbeef, rd 1.
   - Entries then retire in order 0,1,2,3 with the correct data/id; the ROB ends empty.
3. **Retire back-pressure:** head ready, retire_ready = 0 for 3 cycles -> retire_valid and payload stay stable, head unchanged; retire occurs on the cycle retire_ready = 1.
4. **Wrap-around:** 6 dispatch/commit/retire rounds at full throughput -> tags sequence 0,1,2,3,0,1; no spurious full or empty; retired data matches.
5. **Bad commit:** commit to free tag 3 with data 32'h333333 -> commit_err = 1 next cycle; no retire of 32'h333333; a duplicate commit to a ready entry also leaves the stored data unchanged.
6. **Flush and reset:** 3 entries allocated with 1 ready, assert flush -> next cycle empty, tag 0, BREADY = 0 during flush. Assert rst mid-handshake -> all outputs take reset values asynchronously.

Source files
------------

// File: rtl/ncpu32k_rob.sv
// ncpu32k_rob -- reorder buffer at the receiving end of the CDB commit channel.
//
// Dispatch allocates entries in program order and gets back a tag, which is
// the tail index. Functional units complete out of order: the CDB arbiter
// delivers B-packets carrying that tag. Completed entries retire in order,
// from the head, to the register file.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   flush               synchronous flush of all entries
//   disp_*              dispatch A-channel (AVALID/AREADY, rd_addr, rd_we, tag out)
//   rob_commit_*        CDB B-channel (BVALID/BREADY, BDATA, BTAG, id)
//   retire_*            in-order retire channel to the register file
//   commit_err          sticky flag: a commit hit a free or already-ready entry
//
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both high. Ready never depends on valid.
// Neither side withdraws valid or changes the payload until the transfer.

module ncpu32k_rob #(
    parameter int TAG_WIDTH = 2,
    parameter int ID_WIDTH  = 2,
    parameter int DW        = 32,
    parameter int REG_AW    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 disp_AVALID,
    output logic                 disp_AREADY,
    input  logic [REG_AW-1:0]    disp_rd_addr,
    input  logic                 disp_rd_we,
    output logic [TAG_WIDTH-1:0] disp_tag,
    input  logic                 rob_commit_BVALID,
    output logic                 rob_commit_BREADY,
    input  logic [DW-1:0]        rob_commit_BDATA,
    input  logic [TAG_WIDTH-1:0] rob_commit_BTAG,
    input  logic [ID_WIDTH-1:0]  rob_commit_id,
    output logic                 retire_valid,
    input  logic                 retire_ready,
    output logic [DW-1:0]        retire_data,
    output logic [REG_AW-1:0]    retire_rd_addr,
    output logic                 retire_rd_we,
    output logic [ID_WIDTH-1:0]  retire_id,
    output logic                 commit_err
);

    localparam int DEPTH = 1 << TAG_WIDTH;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [TAG_WIDTH:0]   r_head;
    logic [TAG_WIDTH:0]   r_tail;
    logic [DEPTH-1:0]     r_vld;
    logic [DEPTH-1:0]     r_rdy;
    logic                 r_commit_err;

    // Payload storage, not reset.
    logic [DW-1:0]        r_data    [DEPTH];
    logic [REG_AW-1:0]    r_rd_addr [DEPTH];
    logic [DEPTH-1:0]     r_rd_we;
    logic [ID_WIDTH-1:0]  r_id      [DEPTH];

    logic [TAG_WIDTH-1:0] w_head_idx;
    logic [TAG_WIDTH-1:0] w_tail_idx;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_disp_hs;
    logic                 w_cmt_hs;
    logic                 w_cmt_ok;
    logic                 w_ret_hs;
    logic [DEPTH-1:0]     w_vld_nxt;
    logic [DEPTH-1:0]     w_rdy_nxt;

    assign w_head_idx = r_head[TAG_WIDTH-1:0];
    assign w_tail_idx = r_tail[TAG_WIDTH-1:0];
    assign w_empty    = (r_head == r_tail);
    assign w_full     = (w_head_idx == w_tail_idx) & (r_head[TAG_WIDTH] != r_tail[TAG_WIDTH]);

    // Full is evaluated without the same-cycle retire, so a full ROB stalls
    // dispatch for one cycle even when the head leaves.
    assign disp_AREADY       = ~rst & ~w_full & ~flush;
    assign disp_tag          = w_tail_idx;
    assign rob_commit_BREADY = ~rst & ~flush;

    assign retire_valid   = ~w_empty & r_vld[w_head_idx] & r_rdy[w_head_idx];
    assign retire_data    = r_data[w_head_idx];
    assign retire_rd_addr = r_rd_addr[w_head_idx];
    assign retire_rd_we   = r_rd_we[w_head_idx];
    assign retire_id      = r_id[w_head_idx];
    assign commit_err     = r_commit_err;

    assign w_disp_hs = disp_AVALID & disp_AREADY;
    assign w_cmt_hs  = rob_commit_BVALID & rob_commit_BREADY;
    // Only an allocated, not yet completed entry may accept a result.
    assign w_cmt_ok  = w_cmt_hs & r_vld[rob_commit_BTAG] & ~r_rdy[rob_commit_BTAG];
    // Flush wins over a retire in the same cycle.
    assign w_ret_hs  = retire_valid & retire_ready & ~flush;

    // Dispatch, commit and retire always touch distinct entries, so the
    // updates below never collide on the same bit.
    always_comb begin
        w_vld_nxt = r_vld;
        w_rdy_nxt = r_rdy;
        if (w_disp_hs) begin
            w_vld_nxt[w_tail_idx] = 1'b1;
            w_rdy_nxt[w_tail_idx] = 1'b0;
        end
        if (w_cmt_ok) begin
            w_rdy_nxt[rob_commit_BTAG] = 1'b1;
        end
        if (w_ret_hs) begin
            w_vld_nxt[w_head_idx] = 1'b0;
            w_rdy_nxt[w_head_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_vld        <= '0;
            r_rdy        <= '0;
            r_commit_err <= 1'b0;
        end else if (flush) begin
            // commit_err survives a flush; only reset clears it.
            r_head <= '0;
            r_tail <= '0;
            r_vld  <= '0;
            r_rdy  <= '0;
        end else begin
            r_vld <= w_vld_nxt;
            r_rdy <= w_rdy_nxt;
            if (w_disp_hs) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_ret_hs) begin
                r_head <= r_head + 1'b1;
            end
            if (w_cmt_hs & ~w_cmt_ok) begin
                r_commit_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_disp_hs) begin
            r_rd_addr[w_tail_idx] <= disp_rd_addr;
            r_rd_we[w_tail_idx]   <= disp_rd_we;
        end
        if (w_cmt_ok) begin
            r_data[rob_commit_BTAG] <= rob_commit_BDATA;
            r_id[rob_commit_BTAG]   <= rob_commit_id;
        end
    end

endmodule

// File: tb/tb_ncpu32k_rob.sv
// Directed testbench for ncpu32k_rob (DEPTH = 4). Inputs change 1 time unit
// after the rising edge; outputs are sampled 1 unit later, well before the
// next rising edge.

module tb_ncpu32k_rob;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        disp_AVALID;
    logic        disp_AREADY;
    logic [4:0]  disp_rd_addr;
    logic        disp_rd_we;
    logic [1:0]  disp_tag;
    logic        rob_commit_BVALID;
    logic        rob_commit_BREADY;
    logic [31:0] rob_commit_BDATA;
    logic [1:0]  rob_commit_BTAG;
    logic [1:0]  rob_commit_id;
    logic        retire_valid;
    logic        retire_ready;
    logic [31:0] retire_data;
    logic [4:0]  retire_rd_addr;
    logic        retire_rd_we;
    logic [1:0]  retire_id;
    logic        commit_err;

    int checks = 0;
    int errors = 0;

    ncpu32k_rob #(.TAG_WIDTH(2), .ID_WIDTH(2), .DW(32), .REG_AW(5)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .disp_AVALID       (disp_AVALID),
        .disp_AREADY       (disp_AREADY),
        .disp_rd_addr      (disp_rd_addr),
        .disp_rd_we        (disp_rd_we),
        .disp_tag          (disp_tag),
        .rob_commit_BVALID (rob_commit_BVALID),
        .rob_commit_BREADY (rob_commit_BREADY),
        .rob_commit_BDATA  (rob_commit_BDATA),
        .rob_commit_BTAG   (rob_commit_BTAG),
        .rob_commit_id     (rob_commit_id),
        .retire_valid      (retire_valid),
        .retire_ready      (retire_ready),
        .retire_data       (retire_data),
        .retire_rd_addr    (retire_rd_addr),
        .retire_rd_we      (retire_rd_we),
        .retire_id         (retire_id),
        .commit_err        (commit_err)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_disp(input logic v, input logic [4:0] rd);
        disp_AVALID  = v;
        disp_rd_addr = rd;
        disp_rd_we   = v;
    endtask

    task automatic drive_cmt(input logic v, input logic [1:0] tag, input logic [31:0] d, input logic [1:0] id);
        rob_commit_BVALID = v;
        rob_commit_BTAG   = tag;
        rob_commit_BDATA  = d;
        rob_commit_id     = id;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; retire_ready = 1'b0;
        drive_disp(1'b0, 5'd0);
        drive_cmt(1'b0, 2'd0, 32'd0, 2'd0);
        #1;
        checks++; if (disp_AREADY !== 1'b0) begin errors++; $display("FAIL rst_aready: got %b want 0", disp_AREADY); end
        checks++; if (rob_commit_BREADY !== 1'b0) begin errors++; $display("FAIL rst_bready: got %b want 0", rob_commit_BREADY); end
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", retire_valid); end
        checks++; if (disp_tag !== 2'd0) begin errors++; $display("FAIL rst_tag: got %0d want 0", disp_tag); end
        checks++; if (commit_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", commit_err); end
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (disp_AREADY !== 1'b1) begin errors++; $display("FAIL post_rst_aready: got %b want 1", disp_AREADY); end
        checks++; if (rob_commit_BREADY !== 1'b1) begin errors++; $display("FAIL post_rst_bready: got %b want 1", rob_commit_BREADY); end
        tick();
    endtask

    task automatic test_dispatch_full();
        for (int i = 0; i < 4; i++) begin
            drive_disp(1'b1, 5'(i + 1));
            #1;
            checks++; if (disp_AREADY !== 1'b1) begin errors++; $display("FAIL disp_aready[%0d]: got %b want 1", i, disp_AREADY); end
            checks++; if (disp_tag !== 2'(i)) begin errors++; $display("FAIL disp_tag[%0d]: got %0d want %0d", i, disp_tag, i); end
            tick();
        end
        // Fifth request is held off for two cycles.
        drive_disp(1'b1, 5'd9);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (disp_AREADY !== 1'b0) begin errors++; $display("FAIL full_aready[%0d]: got %b want 0", i, disp_AREADY); end
            checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL full_rvalid[%0d]: got %b want 0", i, retire_valid); end
            tick();
        end
        drive_disp(1'b0, 5'd0);
    endtask

    task automatic test_ooo_commit_first();
        drive_cmt(1'b1, 2'd2, 32'h741235, 2'd2);
        #1;
        checks++; if (rob_commit_BREADY !== 1'b1) begin errors++; $display("FAIL ooo_bready: got %b want 1", rob_commit_BREADY); end
        tick();
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL ooo_rv_after_t2: got %b want 0", retire_valid); end
        drive_cmt(1'b1, 2'd0, 32'hbadbeef, 2'd0);
        #1;
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL ooo_no_bypass: got %b want 0", retire_valid); end
        tick();
        drive_cmt(1'b0, 2'd0, 32'd0, 2'd0);
        #1;
        checks++; if (retire_valid !== 1'b1) begin errors++; $display("FAIL ooo_rv_rise: got %b want 1", retire_valid); end
        checks++; if (retire_data !== 32'hbadbeef) begin errors++; $display("FAIL ooo_data0: got %h want 0badbeef", retire_data); end
        checks++; if (retire_rd_addr !== 5'd1) begin errors++; $display("FAIL ooo_rd0: got %0d want 1", retire_rd_addr); end
        checks++; if (retire_id !== 2'd0) begin errors++; $display("FAIL ooo_id0: got %0d want 0", retire_id); end
    endtask

    task automatic test_retire_backpressure();
        retire_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (retire_valid !== 1'b1) begin errors++; $display("FAIL bp_rvalid[%0d]: got %b want 1", i, retire_valid); end
            checks++; if (retire_data !== 32'hbadbeef) begin errors++; $display("FAIL bp_data[%0d]: got %h want 0badbeef", i, retire_data); end
            checks++; if (retire_rd_addr !== 5'd1) begin errors++; $display("FAIL bp_rd[%0d]: got %0d want 1", i, retire_rd_addr); end
            checks++; if (disp_AREADY !== 1'b0) begin errors++; $display("FAIL bp_full[%0d]: got %b want 0", i, disp_AREADY); end
        end
        retire_ready = 1'b1;
        tick();
        retire_ready = 1'b0;
        #1;
        // Head moved to entry 1, which has not completed yet.
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL bp_after_rv: got %b want 0", retire_valid); end
        checks++; if (disp_AREADY !== 1'b1) begin errors++; $display("FAIL bp_after_aready: got %b want 1", disp_AREADY); end
    endtask

    task automatic test_ooo_commit_rest();
        logic [31:0] exp_d [3];
        logic [4:0]  exp_rd [3];
        logic [1:0]  exp_id [3];
        exp_d  = '{32'h11111111, 32'h741235, 32'hcafe0003};
        exp_rd = '{5'd2, 5'd3, 5'd4};
        exp_id = '{2'd1, 2'd2, 2'd3};
        drive_cmt(1'b1, 2'd1, 32'h11111111, 2'd1);
        tick();
        drive_cmt(1'b1, 2'd3, 32'hcafe0003, 2'd3);
        tick();
        drive_cmt(1'b0, 2'd0, 32'd0, 2'd0);
        retire_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (retire_valid !== 1'b1) begin errors++; $display("FAIL ord_rv[%0d]: got %b want 1", i, retire_valid); end
            checks++; if (retire_data !== exp_d[i]) begin errors++; $display("FAIL ord_data[%0d]: got %h want %h", i, retire_data, exp_d[i]); end
            checks++; if (retire_rd_addr !== exp_rd[i]) begin errors++; $display("FAIL ord_rd[%0d]: got %0d want %0d", i, retire_rd_addr, exp_rd[i]); end
            checks++; if (retire_id !== exp_id[i]) begin errors++; $display("FAIL ord_id[%0d]: got %0d want %0d", i, retire_id, exp_id[i]); end
            tick();
        end
        #1;
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL ord_empty_rv: got %b want 0", retire_valid); end
        checks++; if (disp_tag !== 2'd0) begin errors++; $display("FAIL ord_empty_tag: got %0d want 0", disp_tag); end
        checks++; if (commit_err !== 1'b0) begin errors++; $display("FAIL ord_err: got %b want 0", commit_err); end
    endtask

    // Cycle c dispatches op c, commits op c-1 and retires op c-2.
    task automatic test_wraparound();
        logic [1:0] exp_tags [6];
        exp_tags = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        retire_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 6) drive_disp(1'b1, 5'(c + 8)); else drive_disp(1'b0, 5'd0);
            if (c >= 1 && c <= 6) drive_cmt(1'b1, 2'((c - 1) % 4), 32'h1000 + 32'(c - 1), 2'((c - 1) % 4));
            else drive_cmt(1'b0, 2'd0, 32'd0, 2'd0);
            #1;
            if (c < 6) begin
                checks++; if (disp_AREADY !== 1'b1) begin errors++; $display("FAIL wrap_aready[%0d]: got %b want 1", c, disp_AREADY); end
                checks++; if (disp_tag !== exp_tags[c]) begin errors++; $display("FAIL wrap_tag[%0d]: got %0d want %0d", c, disp_tag, exp_tags[c]); end
            end
            checks++; if (retire_valid !== (c >= 2)) begin errors++; $display("FAIL wrap_rv[%0d]: got %b want %b", c, retire_valid, (c >= 2)); end
            if (c >= 2) begin
                checks++; if (retire_data !== 32'h1000 + 32'(c - 2)) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", c, retire_data, 32'h1000 + 32'(c - 2)); end
                checks++; if (retire_rd_addr !== 5'(c + 6)) begin errors++; $display("FAIL wrap_rd[%0d]: got %0d want %0d", c, retire_rd_addr, c + 6); end
            end
            tick();
        end
        drive_disp(1'b0, 5'd0);
        drive_cmt(1'b0, 2'd0, 32'd0, 2'd0);
        #1;
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL wrap_end_rv: got %b want 0", retire_valid); end
        checks++; if (disp_tag !== 2'd2) begin errors++; $display("FAIL wrap_end_tag: got %0d want 2", disp_tag); end
    endtask

    task automatic test_bad_commit();
        retire_ready = 1'b1;
        drive_cmt(1'b1, 2'd3, 32'h333333, 2'd1);
        tick();
        drive_cmt(1'b0, 2'd0, 32'd0, 2'd0);
        #1;
        checks++; if (commit_err !== 1'b1) begin errors++; $display("FAIL bad_err: got %b want 1", commit_err); end
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL bad_rv: got %b want 0", retire_valid); end
        tick();
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL bad_rv2: got %b want 0", retire_valid); end
        retire_ready = 1'b0;
        drive_disp(1'b1, 5'd7);
        tick();
        drive_disp(1'b0, 5'd0);
        drive_cmt(1'b1, 2'd2, 32'haaaa0002, 2'd2);
        tick();
        drive_cmt(1'b1, 2'd2, 32'hdead0002, 2'd3);
        tick();
        drive_cmt(1'b0, 2'd0, 32'd0, 2'd0);
        #1;
        checks++; if (retire_valid !== 1'b1) begin errors++; $display("FAIL dup_rv: got %b want 1", retire_valid); end
        checks++; if (retire_data !== 32'haaaa0002) begin errors++; $display("FAIL dup_data: got %h want aaaa0002", retire_data); end
        checks++; if (retire_id !== 2'd2) begin errors++; $display("FAIL dup_id: got %0d want 2", retire_id); end
        checks++; if (retire_rd_addr !== 5'd7) begin errors++; $display("FAIL dup_rd: got %0d want 7", retire_rd_addr); end
        retire_ready = 1'b1;
        tick();
        retire_ready = 1'b0;
        #1;
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL dup_empty: got %b want 0", retire_valid); end
        checks++; if (disp_tag !== 2'd3) begin errors++; $display("FAIL dup_tag: got %0d want 3", disp_tag); end
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 3; i++) begin
            drive_disp(1'b1, 5'(20 + i));
            tick();
        end
        drive_disp(1'b0, 5'd0);
        drive_cmt(1'b1, 2'd0, 32'h55550000, 2'd0);
        tick();
        // Flush with dispatch and a commit both requested.
        flush = 1'b1;
        drive_disp(1'b1, 5'd30);
        drive_cmt(1'b1, 2'd1, 32'h66660000, 2'd1);
        #1;
        checks++; if (rob_commit_BREADY !== 1'b0) begin errors++; $display("FAIL fl_bready: got %b want 0", rob_commit_BREADY); end
        checks++; if (disp_AREADY !== 1'b0) begin errors++; $display("FAIL fl_aready: got %b want 0", disp_AREADY); end
        tick();
        flush = 1'b0;
        drive_disp(1'b0, 5'd0);
        drive_cmt(1'b0, 2'd0, 32'd0, 2'd0);
        #1;
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL fl_rv: got %b want 0", retire_valid); end
        checks++; if (disp_tag !== 2'd0) begin errors++; $display("FAIL fl_tag: got %0d want 0", disp_tag); end
        checks++; if (disp_AREADY !== 1'b1) begin errors++; $display("FAIL fl_aready_after: got %b want 1", disp_AREADY); end
        checks++; if (commit_err !== 1'b1) begin errors++; $display("FAIL fl_err_kept: got %b want 1", commit_err); end
        // Entry 0 is free after flush, so a commit to it must not retire.
        retire_ready = 1'b1;
        tick();
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL fl_no_stale: got %b want 0", retire_valid); end
        retire_ready = 1'b0;
        // Allocate entry 0, then reset in the middle of the next handshake.
        drive_disp(1'b1, 5'd11);
        tick();
        drive_disp(1'b1, 5'd12);
        drive_cmt(1'b1, 2'd0, 32'h77770000, 2'd1);
        #1;
        checks++; if (disp_tag !== 2'd1) begin errors++; $display("FAIL mr_tag_pre: got %0d want 1", disp_tag); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (disp_AREADY !== 1'b0) begin errors++; $display("FAIL mr_aready: got %b want 0", disp_AREADY); end
        checks++; if (rob_commit_BREADY !== 1'b0) begin errors++; $display("FAIL mr_bready: got %b want 0", rob_commit_BREADY); end
        checks++; if (disp_tag !== 2'd0) begin errors++; $display("FAIL mr_tag: got %0d want 0", disp_tag); end
        checks++; if (commit_err !== 1'b0) begin errors++; $display("FAIL mr_err: got %b want 0", commit_err); end
        drive_disp(1'b0, 5'd0);
        drive_cmt(1'b0, 2'd0, 32'd0, 2'd0);
        tick();
        rst = 1'b0;
        #1;
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL mr_rv: got %b want 0", retire_valid); end
        checks++; if (disp_AREADY !== 1'b1) begin errors++; $display("FAIL mr_aready_after: got %b want 1", disp_AREADY); end
    endtask

    initial begin
        test_reset();
        test_dispatch_full();
        test_ooo_commit_first();
        test_retire_backpressure();
        test_ooo_commit_rest();
        test_wraparound();
        test_bad_commit();
        test_flush_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
